// File: rtl/ofm_packer.sv
// Packs narrow PE result slices into wide AXIS words, one group = REG_NUM words.
// Double-buffered: one group fills while the previous one drains.
module ofm_packer #(
  parameter int IN_WIDTH   = 48,
  parameter int OUT_WIDTH  = 512,
  parameter int REG_NUM    = 3,
  parameter int COMMON_DEN = OUT_WIDTH * REG_NUM,
  parameter int MAX_CNT    = COMMON_DEN / IN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_conv_pulse,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy
);
  localparam int CW = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int WW = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam int NW = $clog2(REG_NUM + 1);

  typedef enum logic {IDLE, SEND} state_t;

  logic [COMMON_DEN-1:0]             fill_buf, next_buf, xfer_buf;
  logic [REG_NUM-1:0][OUT_WIDTH-1:0] drain_buf;
  logic [CW-1:0]                     fill_cnt;
  logic                              fill_full, pend_last;
  logic [NW-1:0]                     pend_nw, grp_nw, xfer_nw;
  state_t                            state;
  logic [WW-1:0]                     wcnt;
  logic [NW-1:0]                     nwords;
  logic                              last_flag;
  logic accept, complete, drain_done, drain_free, transfer, xfer_last;

  assign in_ready   = !fill_full;
  assign accept     = in_valid && !fill_full;
  assign complete   = accept && ((fill_cnt == CW'(MAX_CNT - 1)) || in_last);
  assign drain_done = (state == SEND) && out_ready && (NW'(wcnt) == nwords - 1'b1);
  assign drain_free = (state == IDLE) || drain_done;
  // A parked group (fill_full) and a freshly completing one never coexist.
  assign transfer   = drain_free && (fill_full || complete);
  assign xfer_buf   = fill_full ? fill_buf  : next_buf;
  assign xfer_nw    = fill_full ? pend_nw   : grp_nw;
  assign xfer_last  = fill_full ? pend_last : in_last;
  assign grp_nw     = NW'(((int'(fill_cnt) + 1) * IN_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH);
  assign busy       = (fill_cnt != '0) | fill_full | (state == SEND);

  always_comb begin
    next_buf = fill_buf;
    next_buf[IN_WIDTH * int'(fill_cnt) +: IN_WIDTH] = in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_buf  <= '0;
      fill_cnt  <= '0;
      fill_full <= 1'b0;
      pend_nw   <= '0;
      pend_last <= 1'b0;
    end else if (start_conv_pulse) begin
      fill_buf  <= '0;
      fill_cnt  <= '0;
      fill_full <= 1'b0;
      pend_nw   <= '0;
      pend_last <= 1'b0;
    end else if (fill_full) begin
      if (drain_free) begin
        fill_buf  <= '0;
        fill_full <= 1'b0;
      end
    end else if (accept) begin
      if (complete) begin
        fill_cnt <= '0;
        if (drain_free) begin
          fill_buf <= '0;
        end else begin
          // Park the completed group in place until the drain side frees up.
          fill_buf  <= next_buf;
          fill_full <= 1'b1;
          pend_nw   <= grp_nw;
          pend_last <= in_last;
        end
      end else begin
        fill_buf <= next_buf;
        fill_cnt <= fill_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      drain_buf <= '0;
      wcnt      <= '0;
      nwords    <= '0;
      last_flag <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (start_conv_pulse) begin
      state     <= IDLE;
      drain_buf <= '0;
      wcnt      <= '0;
      nwords    <= '0;
      last_flag <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (transfer) begin
      state     <= SEND;
      drain_buf <= xfer_buf;
      wcnt      <= '0;
      nwords    <= xfer_nw;
      last_flag <= xfer_last;
      out_valid <= 1'b1;
      out_data  <= xfer_buf[OUT_WIDTH-1:0];
      out_last  <= xfer_last && (xfer_nw == NW'(1));
    end else if (state == SEND && out_ready) begin
      if (drain_done) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        wcnt     <= wcnt + 1'b1;
        out_data <= drain_buf[wcnt + 1'b1];
        out_last <= last_flag && (NW'(wcnt + 1'b1) == nwords - 1'b1);
      end
    end
  end

endmodule
